// File: rtl/melody_pkg.sv
// melody_pkg: shared constants for the melody tone generator.
//   - one-hot note codes (DO..SI) and octave codes (LOW/MID/HIGH)
//   - mid-octave frequency table in integer Hz
//   - the 32-slot "Little Star" song table, word = {note[6:0], pitch[2:0]}
//   - tone-generator state type and a half-period helper
package melody_pkg;

    localparam logic [6:0] NOTE_REST = 7'b0000000;
    localparam logic [6:0] NOTE_DO   = 7'b0000001;
    localparam logic [6:0] NOTE_RE   = 7'b0000010;
    localparam logic [6:0] NOTE_MI   = 7'b0000100;
    localparam logic [6:0] NOTE_FA   = 7'b0001000;
    localparam logic [6:0] NOTE_SO   = 7'b0010000;
    localparam logic [6:0] NOTE_LA   = 7'b0100000;
    localparam logic [6:0] NOTE_SI   = 7'b1000000;

    localparam logic [2:0] PITCH_LOW  = 3'b001;
    localparam logic [2:0] PITCH_MID  = 3'b010;
    localparam logic [2:0] PITCH_HIGH = 3'b100;

    localparam int unsigned SONG_SLOTS = 32;

    // Index i matches note bit i (C, D, E, F, G, A, B).
    localparam int unsigned FREQ_MID_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

    localparam logic [9:0] W_C = {NOTE_DO, PITCH_MID};
    localparam logic [9:0] W_D = {NOTE_RE, PITCH_MID};
    localparam logic [9:0] W_E = {NOTE_MI, PITCH_MID};
    localparam logic [9:0] W_F = {NOTE_FA, PITCH_MID};
    localparam logic [9:0] W_G = {NOTE_SO, PITCH_MID};
    localparam logic [9:0] W_A = {NOTE_LA, PITCH_MID};
    localparam logic [9:0] W_R = 10'b0;

    localparam logic [9:0] SONG [SONG_SLOTS] = '{
        W_C, W_C, W_G, W_G, W_A, W_A, W_G, W_R,
        W_F, W_F, W_E, W_E, W_D, W_D, W_C, W_R,
        W_G, W_G, W_F, W_F, W_E, W_E, W_D, W_R,
        W_G, W_G, W_F, W_F, W_E, W_E, W_D, W_R
    };

    typedef enum logic {
        ST_SILENT = 1'b0,
        ST_SOUND  = 1'b1
    } tone_state_t;

    // Clocks per half period of a square wave at freq_hz, evaluated at elaboration.
    function automatic logic [31:0] half_of(input int unsigned clk_hz, input int unsigned freq_hz);
        return 32'(clk_hz / (2 * freq_hz));
    endfunction

endpackage

// File: rtl/melody_tone_gen_rom.sv
// melody_rom: combinational song lookup.
//   index [7:0] : melody slot
//   note  [6:0] : one-hot note, 0 = rest
//   pitch [2:0] : one-hot octave, 0 = rest
// Slots at or beyond ROM_DEPTH (or beyond the 32-entry table) read as rest.
module melody_rom
    import melody_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 32
) (
    input  logic [7:0] index,
    output logic [6:0] note,
    output logic [2:0] pitch
);

    logic [9:0] word;

    always_comb begin
        word = W_R;
        if ((32'(index) < ROM_DEPTH) && (index < 8'(SONG_SLOTS))) begin
            word = SONG[index[4:0]];
        end
    end

    assign note  = word[9:3];
    assign pitch = word[2:0];

endmodule

// File: rtl/melody_tone_gen.sv
// melody_tone_gen: song ROM plus square-wave tone generator.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   index     : melody slot to play
//   stop      : 1 = silence (gap between notes)
//   note      : ROM note field (combinational from index)
//   pitch     : ROM octave field (combinational from index)
//   speaker   : square-wave audio
//   sel       : audio path select
//   mark_led  : 1 while a tone is sounding
// Build option SEL_AUTO_MUTE_EN: sel follows the sounding state so the
// amplifier is off during gaps, rests and reset; otherwise sel is tied high.
//
// state     | meaning
// ST_SILENT | stop, rest or invalid word; speaker and counter held at 0
// ST_SOUND  | tone running; counter wraps at HALF-1 and toggles speaker
module melody_tone_gen
    import melody_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned ROM_DEPTH   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] index,
    input  logic       stop,
    output logic [6:0] note,
    output logic [2:0] pitch,
    output logic       speaker,
    output logic       sel,
    output logic       mark_led
);

    localparam logic [31:0] HALF_MID [7] = '{
        half_of(CLK_FREQ_HZ, FREQ_MID_HZ[0]),
        half_of(CLK_FREQ_HZ, FREQ_MID_HZ[1]),
        half_of(CLK_FREQ_HZ, FREQ_MID_HZ[2]),
        half_of(CLK_FREQ_HZ, FREQ_MID_HZ[3]),
        half_of(CLK_FREQ_HZ, FREQ_MID_HZ[4]),
        half_of(CLK_FREQ_HZ, FREQ_MID_HZ[5]),
        half_of(CLK_FREQ_HZ, FREQ_MID_HZ[6])
    };

    tone_state_t state_q, state_nx;
    logic [31:0] cnt_q, cnt_nx;
    logic        spk_q, spk_nx;
    logic [9:0]  tone_q;
    logic [9:0]  tone_word;
    logic [31:0] half_mid;
    logic [31:0] half;
    logic        silent;

    melody_rom #(
        .ROM_DEPTH (ROM_DEPTH)
    ) u_rom (
        .index (index),
        .note  (note),
        .pitch (pitch)
    );

    assign tone_word = {note, pitch};
    assign silent    = stop || !$onehot(note) || !$onehot(pitch);

    always_comb begin
        half_mid = HALF_MID[0];
        for (int i = 0; i < 7; i++) begin
            if (note[i]) begin
                half_mid = HALF_MID[i];
            end
        end
    end

    always_comb begin
        half = half_mid;
        if (pitch == PITCH_LOW) begin
            half = half_mid << 1;
        end else if (pitch == PITCH_HIGH) begin
            half = half_mid >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SILENT;
            cnt_q   <= '0;
            spk_q   <= 1'b0;
            tone_q  <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            spk_q   <= spk_nx;
            tone_q  <= tone_word;
        end
    end

    // A tone change only restarts the phase when a tone was already running;
    // coming out of silence the counter is already 0 and counts straight away,
    // which puts the first rising edge HALF cycles after sounding begins.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        spk_nx   = spk_q;
        if (silent) begin
            state_nx = ST_SILENT;
            cnt_nx   = '0;
            spk_nx   = 1'b0;
        end else if ((state_q == ST_SOUND) && (tone_word != tone_q)) begin
            cnt_nx = '0;
            spk_nx = 1'b0;
        end else begin
            state_nx = ST_SOUND;
            if (cnt_q == half - 32'd1) begin
                cnt_nx = '0;
                spk_nx = ~spk_q;
            end else begin
                cnt_nx = cnt_q + 32'd1;
            end
        end
    end

    assign speaker  = spk_q;
    assign mark_led = (state_q == ST_SOUND);

`ifdef SEL_AUTO_MUTE_EN
    assign sel = (state_q == ST_SOUND);
`else
    assign sel = 1'b1;
`endif

endmodule

// File: tb/tb_melody_tone_gen.sv
module tb_melody_tone_gen;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int          LIMIT  = 6000;

    logic       clk;
    logic       rst_n;
    logic [7:0] index;
    logic       stop;
    logic [6:0] note;
    logic [2:0] pitch;
    logic       speaker;
    logic       sel;
    logic       mark_led;

    int errors = 0;
    int checks = 0;

    melody_tone_gen #(
        .CLK_FREQ_HZ (CLK_HZ),
        .ROM_DEPTH   (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (index),
        .stop     (stop),
        .note     (note),
        .pitch    (pitch),
        .speaker  (speaker),
        .sel      (sel),
        .mark_led (mark_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    string song_s = "CCGGAAG-FFEEDDC-GGFFEED-GGFFEED-";
    string notes_s = "CDEFGAB";
    int    freq_tab [7] = '{262, 294, 330, 349, 392, 440, 494};

    function automatic logic [9:0] model_rom(input logic [7:0] idx);
        byte c;
        logic [9:0] w;
        w = 10'b0;
        if (idx < 8'd32) begin
            c = song_s[idx];
            for (int k = 0; k < 7; k++) begin
                if (notes_s[k] == c) begin
                    w = {7'(1 << k), 3'b010};
                end
            end
        end
        return w;
    endfunction

    function automatic int model_half(input logic [9:0] w);
        int f;
        int h;
        f = 1;
        for (int k = 0; k < 7; k++) begin
            if (w[3 + k]) f = freq_tab[k];
        end
        h = CLK_HZ / (2 * f);
        if (w[2:0] == 3'b001) h = h * 2;
        if (w[2:0] == 3'b100) h = h / 2;
        return h;
    endfunction

    function automatic bit legal_tone(input logic [9:0] w);
        return ($countones(w[9:3]) == 1) && ($countones(w[2:0]) == 1);
    endfunction

    // m_n: cycles into the current tone; a fresh start from silence has already
    // spent its first cycle, a mid-tone change restarts at 0.
    bit         m_act;
    int         m_n;
    logic [9:0] m_word;

    always @(posedge clk or negedge rst_n) begin
        logic [9:0] w;
        if (!rst_n) begin
            m_act  = 1'b0;
            m_n    = 0;
            m_word = 10'b0;
        end else begin
            w = model_rom(index);
            if (stop || !legal_tone(w)) begin
                m_act = 1'b0;
                m_n   = 0;
            end else if (m_act && (w != m_word)) begin
                m_n = 0;
            end else if (!m_act) begin
                m_act = 1'b1;
                m_n   = 1;
            end else begin
                m_n = m_n + 1;
            end
            m_word = w;
        end
    end

    function automatic logic exp_speaker();
        if (!m_act) return 1'b0;
        return ((m_n / model_half(m_word)) % 2) == 1;
    endfunction

    function automatic logic exp_sel();
`ifdef SEL_AUTO_MUTE_EN
        return m_act;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [9:0] w;
        if (rst_n) begin
            w = model_rom(index);
            check("note",     32'(note),     32'(w[9:3]));
            check("pitch",    32'(pitch),    32'(w[2:0]));
            check("speaker",  32'(speaker),  32'(exp_speaker()));
            check("mark_led", 32'(mark_led), 32'(m_act));
            check("sel",      32'(sel),      32'(exp_sel()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [7:0] idx, input logic stp);
        @(posedge clk);
        #2;
        index = idx;
        stop  = stp;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts rising clk edges from now until speaker reaches lvl.
    task automatic edges_until(input logic lvl, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((speaker !== lvl) && (n < LIMIT));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        index = 8'd0;
        stop  = 1'b1;
        #23;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_speaker", 32'(speaker),  32'd0);
        check("rst_mark",    32'(mark_led), 32'd0);
`ifdef SEL_AUTO_MUTE_EN
        check("rst_sel", 32'(sel), 32'd0);
`else
        check("rst_sel", 32'(sel), 32'd1);
`endif

        // C4 from silence: rise after HALF=1908 edges, then half period 1908.
        drive(8'd0, 1'b0);
        #1;
        check("c_note",  32'(note),  32'd1);
        check("c_pitch", 32'(pitch), 32'd2);
        edges_until(1'b1, n);
        check("c_first_rise", 32'(n), 32'd1908);
        check("c_mark", 32'(mark_led), 32'd1);
        edges_until(1'b0, n);
        check("c_half", 32'(n), 32'd1908);

        // Change to A4: change edge clears phase, rise 1136 edges after it.
        drive(8'd4, 1'b0);
        edges_until(1'b1, n);
        check("a_after_change", 32'(n), 32'd1137);

        // stop pulsed 500 cycles into a high half.
        wait_edges(500);
        drive(8'd4, 1'b1);
        wait_edges(1);
        check("stop_speaker", 32'(speaker), 32'd0);
        drive(8'd4, 1'b0);
        edges_until(1'b1, n);
        check("a_restart", 32'(n), 32'd1136);

        // C -> G mid-period.
        drive(8'd0, 1'b0);
        wait_edges(2500);
        drive(8'd2, 1'b0);
        wait_edges(1);
        check("cg_cleared", 32'(speaker), 32'd0);
        edges_until(1'b1, n);
        check("g_after_change", 32'(n), 32'd1275);

        // Rest slots and out-of-range index.
        foreach (song_s[k]) begin end
        for (int r = 0; r < 3; r++) begin
            logic [7:0] ridx;
            ridx = (r == 0) ? 8'd7 : (r == 1) ? 8'd31 : 8'd200;
            drive(ridx, 1'b0);
            wait_edges(3);
            check("rest_note",    32'(note),     32'd0);
            check("rest_pitch",   32'(pitch),    32'd0);
            check("rest_speaker", 32'(speaker),  32'd0);
            check("rest_mark",    32'(mark_led), 32'd0);
        end

        // Asynchronous reset while the speaker is high.
        drive(8'd0, 1'b0);
        wait_edges(2000);
        check("pre_reset_speaker", 32'(speaker), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_speaker", 32'(speaker),  32'd0);
        check("arst_mark",    32'(mark_led), 32'd0);
`ifdef SEL_AUTO_MUTE_EN
        check("arst_sel", 32'(sel), 32'd0);
`else
        check("arst_sel", 32'(sel), 32'd1);
`endif
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        // Randomised segments checked by the per-cycle compare.
        for (int s = 0; s < 30; s++) begin
            logic [7:0] ridx;
            int sel_r;
            sel_r = $urandom_range(0, 9);
            if (sel_r < 7)      ridx = 8'($urandom_range(0, 31));
            else if (sel_r < 9) ridx = 8'($urandom_range(32, 40));
            else                ridx = 8'($urandom_range(200, 255));
            drive(ridx, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(1, 2500)) @(posedge clk);
        end

        wait_edges(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
